// File: rtl/alu_mc_responder_pkg.sv
// -----------------------------------------------------------------------------
// alu_mc_responder_pkg
// Shared parameters and types for the multi-cycle ALU responder:
//   OPERAND_MAX_DATA_WIDTH : default operand width
//   alu_op_t               : 3-bit opcode encoding (6 and 7 are illegal)
//   alu_state_t            : responder FSM states
//   op_is_legal()          : opcode legality helper
// -----------------------------------------------------------------------------
package alu_mc_responder_pkg;

  localparam int OPERAND_MAX_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_ILL6 = 3'd6,
    OP_ILL7 = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic op_is_legal(input alu_op_t op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_mc_responder_if.sv
// -----------------------------------------------------------------------------
// alu_mc_responder_if
// Request/response handshake bundle for alu_mc_responder.
//   in_valid/in_ready   : request handshake
//   in_a/in_b/in_op     : request payload
//   out_valid/out_ready : response handshake
//   out_result/out_err  : response payload (qualified by out_valid)
// master = requester/consumer side, slave = responder side.
// -----------------------------------------------------------------------------
interface alu_mc_responder_if
  import alu_mc_responder_pkg::*;
#(
  parameter int DATA_W = OPERAND_MAX_DATA_WIDTH
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_a;
  logic [DATA_W-1:0]     in_b;
  alu_op_t               in_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_result;
  logic                  out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_err
  );

endinterface

// File: rtl/alu_mc_mul.sv
// -----------------------------------------------------------------------------
// alu_mc_mul
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : load operands; bit 0 is consumed on the loading edge
//   a_i, b_i     : multiplicand / multiplier
//   done_o       : product complete (held until the next start_i)
//   product_o    : 2*DATA_W-bit product
// Bit 0 is folded into the load so the product is final DATA_W-1 cycles
// after the loading edge. DATA_W must be at least 2.
// -----------------------------------------------------------------------------
module alu_mc_mul #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                done_o,
  output logic [2*DATA_W-1:0] product_o
);

  localparam int RES_W = 2 * DATA_W;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  logic [RES_W-1:0]  acc_q, acc_d;
  logic [RES_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state: load on start, otherwise accumulate one multiplier bit per cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    bits_d   = bits_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (start_i) begin
      if (b_i[0]) begin
        acc_d = {{DATA_W{1'b0}}, a_i};
      end else begin
        acc_d = {RES_W{1'b0}};
      end
      mcand_d  = {{(DATA_W-1){1'b0}}, a_i, 1'b0};
      mplier_d = {1'b0, b_i[DATA_W-1:1]};
      bits_d   = BIT_ONE;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = {mcand_q[RES_W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
      bits_d   = bits_q + BIT_ONE;
      if ((bits_q + BIT_ONE) == BIT_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {RES_W{1'b0}};
      mcand_q  <= {RES_W{1'b0}};
      mplier_q <= {DATA_W{1'b0}};
      bits_q   <= {BIT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      bits_q   <= bits_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_mc_responder.sv
// -----------------------------------------------------------------------------
// alu_mc_responder
// Multi-cycle ALU behind a valid/ready request and response handshake.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (aborts any operation)
//   bus_io  : alu_mc_responder_if.slave (request in, result out)
// IDLE accepts one request, EXEC runs 1 cycle (MUL_CYCLES for MUL), DONE
// presents a registered result until the consumer takes it.
// MUL_CYCLES must be >= DATA_W so the multiplier finishes inside EXEC.
// -----------------------------------------------------------------------------
module alu_mc_responder
  import alu_mc_responder_pkg::*;
#(
  parameter int DATA_W     = OPERAND_MAX_DATA_WIDTH,
  parameter int MUL_CYCLES = DATA_W
) (
  input logic               clk,
  input logic               rst,
  alu_mc_responder_if.slave bus_io
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES);

  alu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  alu_op_t           op_q, op_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  logic              accept_s, retire_s, mul_start_s, mul_done_s, last_iter_s;
  logic [CNT_W-1:0]  target_s;
  logic [RES_W-1:0]  mul_product_s, alu_result_s;

  // ready_q is only high in IDLE, so it alone qualifies the accept.
  assign accept_s    = ready_q && bus_io.in_valid;
  assign retire_s    = valid_q && bus_io.out_ready;
  assign mul_start_s = accept_s && (bus_io.in_op == OP_MUL);

  alu_mc_mul #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start_s),
    .a_i       (bus_io.in_a),
    .b_i       (bus_io.in_b),
    .done_o    (mul_done_s),
    .product_o (mul_product_s)
  );

  // Single-cycle datapath on the latched operands; illegal opcodes give zero.
  always_comb begin
    alu_result_s = {RES_W{1'b0}};
    case (op_q)
      OP_ADD:  alu_result_s = {{DATA_W{1'b0}}, a_q} + {{DATA_W{1'b0}}, b_q};
      // Subtracting at full width yields the sign-extended difference.
      OP_SUB:  alu_result_s = {{DATA_W{1'b0}}, a_q} - {{DATA_W{1'b0}}, b_q};
      OP_AND:  alu_result_s = {{DATA_W{1'b0}}, a_q & b_q};
      OP_OR:   alu_result_s = {{DATA_W{1'b0}}, a_q | b_q};
      OP_XOR:  alu_result_s = {{DATA_W{1'b0}}, a_q ^ b_q};
      default: alu_result_s = {RES_W{1'b0}};
    endcase
  end

  // EXEC length per opcode and end-of-EXEC detection.
  always_comb begin
    if (op_q == OP_MUL) begin
      target_s    = CNT_MUL;
      last_iter_s = ((cnt_q + CNT_ONE) == target_s) && mul_done_s;
    end else begin
      target_s    = CNT_ONE;
      last_iter_s = ((cnt_q + CNT_ONE) == target_s);
    end
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d     = bus_io.in_a;
          b_d     = bus_io.in_b;
          op_d    = bus_io.in_op;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (last_iter_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_DONE;
          err_d   = !op_is_legal(op_q);
          if (op_q == OP_MUL) begin
            result_d = mul_product_s;
          end else begin
            result_d = alu_result_s;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (retire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    // Handshake outputs follow the next state so they are registered.
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // State and output registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_q      <= {DATA_W{1'b0}};
      b_q      <= {DATA_W{1'b0}};
      op_q     <= OP_ADD;
      result_q <= {RES_W{1'b0}};
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign bus_io.in_ready   = ready_q;
  assign bus_io.out_valid  = valid_q;
  assign bus_io.out_result = result_q;
  assign bus_io.out_err    = err_q;

endmodule
